gnn_combine: RTL



---
 rtl/gnn_pkg.sv | 21 ++
 rtl/gnn_mac_lane.sv | 40 ++++
 rtl/gnn_combine.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gnn_pkg.sv
// Shared definitions for the GNN combine stage: fixed node/feature counts,
// the controller state encoding and the flat-bus offset helper.
package gnn_pkg;

  localparam int NODES        = 4;
  localparam int FEATS        = 4;
  localparam int DEF_ACC_SIZE = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of element (n,j) on a flat NODES*FEATS bus of acc_size-wide entries.
  function automatic int acc_idx(input int n, input int j,
                                 input int acc_size = DEF_ACC_SIZE);
    return (n * FEATS + j) * acc_size;
  endfunction

endpackage

// File: rtl/gnn_mac_lane.sv
// One signed multiply-accumulate lane for a single (node, out-feature) pair.
// clr has priority over en; both act on the rising clock edge.
module gnn_mac_lane #(
  parameter int A_W   = 7,
  parameter int W_W   = 4,
  parameter int ACC_W = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [W_W-1:0]   w,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + W_W;

  logic signed [P_W-1:0]   a_ext;
  logic signed [P_W-1:0]   w_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;

  // Operands are widened to the full product width so the multiply is exact.
  assign a_ext    = {{W_W{a[A_W-1]}}, a};
  assign w_ext    = {{A_W{w[W_W-1]}}, w};
  assign prod     = a_ext * w_ext;
  assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/gnn_combine.sv
// Combine stage: out[n][j] = sum_f aggr[n][f]*W[f][j] over four MAC cycles.
// Define GNN_COMBINE_RELU_EN to clamp negative results to zero at write-out.
module gnn_combine
  import gnn_pkg::*;
#(
  parameter int AGGR_OUT_SIZE = 7,
  parameter int W_SIZE        = 4,
  parameter int ACC_SIZE      = AGGR_OUT_SIZE + W_SIZE + 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [NODES*FEATS*AGGR_OUT_SIZE-1:0] aggr_in,
  input  logic [FEATS*FEATS*W_SIZE-1:0]        w_in,
  output logic                                busy,
  output logic                                out_valid,
  output logic [NODES*FEATS*ACC_SIZE-1:0]      comb_out,
  output logic                                overrun
);

  // Handshake: in_valid is a one-cycle start pulse, accepted only in IDLE.
  // There is no back-pressure; a pulse while busy is dropped and latches
  // overrun. out_valid pulses for one cycle when comb_out is updated, and
  // comb_out then holds until the next job completes.

  state_t state;
  state_t state_nxt;
  logic [1:0] k;
  logic [1:0] k_nxt;
  logic capture;
  logic lane_clr;
  logic lane_en;
  logic load_out;

  logic [NODES*FEATS*AGGR_OUT_SIZE-1:0] aggr_q;
  logic [FEATS*FEATS*W_SIZE-1:0]        w_q;
  logic [NODES*FEATS*ACC_SIZE-1:0]      comb_nxt;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    capture   = 1'b0;
    lane_clr  = 1'b0;
    lane_en   = 1'b0;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          lane_clr  = 1'b1;
          k_nxt     = 2'd0;
          state_nxt = MAC;
        end
      end
      MAC: begin
        lane_en = 1'b1;
        k_nxt   = k + 2'd1;
        if (k == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        load_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= 2'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Local copies decouple the job in flight from later input changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aggr_q <= '0;
      w_q    <= '0;
    end else if (capture) begin
      aggr_q <= aggr_in;
      w_q    <= w_in;
    end
  end

  for (genvar n = 0; n < NODES; n++) begin : g_node
    for (genvar j = 0; j < FEATS; j++) begin : g_feat
      logic signed [AGGR_OUT_SIZE-1:0] a_sel;
      logic signed [W_SIZE-1:0]        w_sel;
      logic signed [ACC_SIZE-1:0]      acc;

      // Step k consumes column k of this node's row and row k of W.
      assign a_sel = aggr_q[(n * FEATS + int'(k)) * AGGR_OUT_SIZE +: AGGR_OUT_SIZE];
      assign w_sel = w_q[(int'(k) * FEATS + j) * W_SIZE +: W_SIZE];

      gnn_mac_lane #(
        .A_W   (AGGR_OUT_SIZE),
        .W_W   (W_SIZE),
        .ACC_W (ACC_SIZE)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lane_clr),
        .en    (lane_en),
        .a     (a_sel),
        .w     (w_sel),
        .acc   (acc)
      );

`ifdef GNN_COMBINE_RELU_EN
      assign comb_nxt[acc_idx(n, j, ACC_SIZE) +: ACC_SIZE] = acc[ACC_SIZE-1] ? '0 : acc;
`else
      assign comb_nxt[acc_idx(n, j, ACC_SIZE) +: ACC_SIZE] = acc;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comb_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= load_out;
      if (load_out) begin
        comb_out <= comb_nxt;
      end
      if (in_valid && busy) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
